kbd_link_scheduler: RTL

- Transaction scheduler for the NeXT keyboard/mouse serial link.
- Decides what the bit-level link engine sends in each poll slot: link-reset command, LED update, or alternating keyboard/mouse query.
- Hands one command at a time to the engine, waits for the 21-bit response or a timeout, classifies the response, and tracks link readiness.
- Sits between the monitor-side register logic and the serializer/deserializer; runs on the monitor clock.

---
 rtl/kbd_link_scheduler.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/kbd_link_scheduler.sv
// Poll-slot scheduler for the NeXT keyboard/mouse serial link: picks reset/LED/query per slot and tracks link readiness.
// Build option KBD_SCHED_MOUSE_EN: alternate keyboard and mouse queries (otherwise only the keyboard is polled).
module kbd_link_scheduler #(
    parameter int SLOT_TICKS         = 40,
    parameter int RESP_TIMEOUT_TICKS = 30,
    parameter int MAX_PENDING        = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        led_data_valid,
    input  logic [1:0]  led_data_in,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [20:0] cmd_word,
    output logic        cmd_short,
    output logic        cmd_expect_resp,
    input  logic        resp_valid,
    input  logic [20:0] resp_data,
    output logic        data_available,
    output logic        is_mouse_data,
    output logic [15:0] keyboard_data,
    output logic [1:0]  link_state
);
    localparam int SLOT_W = (SLOT_TICKS > 2) ? $clog2(SLOT_TICKS) : 1;
    localparam int TO_W   = (RESP_TIMEOUT_TICKS > 2) ? $clog2(RESP_TIMEOUT_TICKS) : 1;
    localparam int PC_W   = (MAX_PENDING > 0) ? $clog2(MAX_PENDING + 1) : 1;

    localparam logic [20:0] RESET_CMD = 21'h1EFC00;
    localparam logic [20:0] ACK_MASK  = 21'h1FFFFE;
    localparam logic [20:0] ACK_PAT   = 21'h100600;
    localparam logic [20:0] DATA_MASK = 21'h100E00;
    localparam logic [20:0] DATA_PAT  = 21'h000400;
    localparam logic [7:0]  KBD_QUERY   = 8'h08;
    localparam logic [7:0]  MOUSE_QUERY = 8'h88;

    localparam logic [1:0] LS_NOT_READY = 2'b00;
    localparam logic [1:0] LS_PENDING   = 2'b01;
    localparam logic [1:0] LS_READY     = 2'b10;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state_q;
    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [TO_W-1:0]   wait_cnt_q;
    logic [PC_W-1:0]   pend_cnt_q;
    logic [1:0]        link_q;
    logic [1:0]        led_val_q;
    logic              led_pend_q;
    logic              cmd_valid_q, cmd_short_q, cmd_exp_q;
    logic [20:0]       cmd_word_q;
    logic              data_avail_q;
    logic [15:0]       kbd_data_q;
    logic              slot_hit, timeout_hit, resp_is_ack, resp_is_data;

`ifdef KBD_SCHED_MOUSE_EN
    logic mouse_next_q, src_mouse_q, is_mouse_q;
    assign is_mouse_data = is_mouse_q;
`else
    assign is_mouse_data = 1'b0;
`endif

    // The slot counter free-runs in every state, so a boundary that lands outside IDLE is simply lost.
    always_comb begin
        slot_hit    = tick && (slot_cnt_q == SLOT_W'(SLOT_TICKS - 1));
        slot_cnt_d  = slot_cnt_q;
        if (tick) begin
            slot_cnt_d = slot_hit ? '0 : slot_cnt_q + SLOT_W'(1);
        end
        timeout_hit  = tick && (wait_cnt_q == TO_W'(RESP_TIMEOUT_TICKS - 1));
        resp_is_ack  = (resp_data & ACK_MASK) == ACK_PAT;
        resp_is_data = (resp_data & DATA_MASK) == DATA_PAT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            slot_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            pend_cnt_q   <= '0;
            link_q       <= LS_NOT_READY;
            led_val_q    <= 2'b00;
            led_pend_q   <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_short_q  <= 1'b0;
            cmd_exp_q    <= 1'b0;
            cmd_word_q   <= '0;
            data_avail_q <= 1'b0;
            kbd_data_q   <= '0;
`ifdef KBD_SCHED_MOUSE_EN
            mouse_next_q <= 1'b0;
            src_mouse_q  <= 1'b0;
            is_mouse_q   <= 1'b0;
`endif
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            data_avail_q <= 1'b0;
            if (led_data_valid) begin
                led_val_q  <= led_data_in;
                led_pend_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (slot_hit) begin
                        state_q     <= ISSUE;
                        cmd_valid_q <= 1'b1;
                        if (link_q == LS_NOT_READY) begin
                            cmd_word_q  <= RESET_CMD;
                            cmd_short_q <= 1'b0;
                            cmd_exp_q   <= 1'b1;
                            link_q      <= LS_PENDING;
                        end else if (led_pend_q && !led_data_valid) begin
                            // A write landing on the slot cycle defers the update so the newest value goes out.
                            cmd_word_q  <= {12'b000000001110, led_val_q, 7'b0};
                            cmd_short_q <= 1'b0;
                            cmd_exp_q   <= 1'b0;
                            led_pend_q  <= 1'b0;
                        end else begin
                            cmd_short_q <= 1'b1;
                            cmd_exp_q   <= 1'b1;
`ifdef KBD_SCHED_MOUSE_EN
                            cmd_word_q   <= {(mouse_next_q ? MOUSE_QUERY : KBD_QUERY), 13'd0};
                            src_mouse_q  <= mouse_next_q;
                            mouse_next_q <= !mouse_next_q;
`else
                            cmd_word_q   <= {KBD_QUERY, 13'd0};
`endif
                        end
                    end
                end

                ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        wait_cnt_q  <= '0;
                        state_q     <= cmd_exp_q ? WAIT : IDLE;
                    end
                end

                WAIT: begin
                    // A response wins over a timeout falling on the same cycle.
                    if (resp_valid) begin
                        state_q <= IDLE;
                        if (resp_is_ack) begin
                            link_q     <= LS_READY;
                            pend_cnt_q <= '0;
                        end else if (resp_is_data && (link_q == LS_READY)) begin
                            kbd_data_q   <= {resp_data[19:12], resp_data[8:1]};
                            data_avail_q <= 1'b1;
`ifdef KBD_SCHED_MOUSE_EN
                            is_mouse_q   <= src_mouse_q;
`endif
                        end
                    end else if (timeout_hit) begin
                        state_q <= IDLE;
                        if (link_q == LS_PENDING) begin
                            if (pend_cnt_q == PC_W'(MAX_PENDING)) begin
                                link_q     <= LS_NOT_READY;
                                pend_cnt_q <= '0;
                            end else begin
                                pend_cnt_q <= pend_cnt_q + PC_W'(1);
                            end
                        end else if (link_q == LS_READY) begin
                            link_q <= LS_NOT_READY;
                        end
                    end else if (tick) begin
                        wait_cnt_q <= wait_cnt_q + TO_W'(1);
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_valid       = cmd_valid_q;
    assign cmd_word        = cmd_word_q;
    assign cmd_short       = cmd_short_q;
    assign cmd_expect_resp = cmd_exp_q;
    assign data_available  = data_avail_q;
    assign keyboard_data   = kbd_data_q;
    assign link_state      = link_q;
endmodule
